// File: rtl/axi_mux_aw_w_arbiter.sv
// Write-side arbiter for a crossbar mux: round-robin AW grant, W routed in AW order.
// Define AXI_MUX_W_BYPASS_EN to let W fall through an empty write-order FIFO.
module axi_mux_aw_w_arbiter #(
  parameter int unsigned NoSlvPorts  = 4,
  parameter int unsigned MaxWTrans   = 8,
  parameter int unsigned SelectWidth = $clog2(NoSlvPorts)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NoSlvPorts-1:0]  slv_aw_valid_i,
  output logic [NoSlvPorts-1:0]  slv_aw_ready_o,
  output logic                   mst_aw_valid_o,
  input  logic                   mst_aw_ready_i,
  output logic [SelectWidth-1:0] mst_aw_sel_o,
  input  logic [NoSlvPorts-1:0]  slv_w_valid_i,
  input  logic [NoSlvPorts-1:0]  slv_w_last_i,
  output logic [NoSlvPorts-1:0]  slv_w_ready_o,
  output logic                   mst_w_valid_o,
  input  logic                   mst_w_ready_i,
  output logic [SelectWidth-1:0] mst_w_sel_o,
  output logic                   w_fifo_full_o,
  output logic                   w_fifo_empty_o
);
  localparam int unsigned CntWidth = $clog2(MaxWTrans + 1);
  localparam int unsigned PtrWidth = (MaxWTrans > 1) ? $clog2(MaxWTrans) : 1;
  localparam logic [CntWidth-1:0]    CntMax  = CntWidth'(MaxWTrans);
  localparam logic [PtrWidth-1:0]    PtrLast = PtrWidth'(MaxWTrans - 1);
  localparam logic [SelectWidth-1:0] SelLast = SelectWidth'(NoSlvPorts - 1);

  typedef enum logic [0:0] {AwIdle, AwLocked} aw_state_e;

  aw_state_e              r_state, w_state_d;
  logic [SelectWidth-1:0] r_aw_sel, w_aw_sel_d;
  logic [SelectWidth-1:0] r_rr_ptr, w_rr_ptr_d;
  logic [SelectWidth-1:0] r_fifo [MaxWTrans];
  logic [PtrWidth-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CntWidth-1:0]    r_count;

  logic                   w_arb_found;
  logic [SelectWidth-1:0] w_arb_idx, w_cand;
  logic                   w_aw_hs, w_pop, w_fifo_push, w_fifo_pop;
  logic                   w_fifo_empty, w_w_active;
  logic [SelectWidth-1:0] w_w_sel, w_head;

  assign w_fifo_empty   = (r_count == '0);
  assign w_head         = r_fifo[r_rd_ptr];
  assign w_fifo_full_o  = (r_count == CntMax);
  assign w_fifo_empty_o = w_fifo_empty;
  assign mst_aw_sel_o   = r_aw_sel;

  // First valid requester at or after the round-robin pointer, wrapping upward.
  always_comb begin
    w_arb_found = 1'b0;
    w_arb_idx   = '0;
    w_cand      = '0;
    for (int unsigned k = 0; k < NoSlvPorts; k++) begin
      w_cand = SelectWidth'((32'(r_rr_ptr) + k) % NoSlvPorts);
      if (!w_arb_found && slv_aw_valid_i[w_cand]) begin
        w_arb_found = 1'b1;
        w_arb_idx   = w_cand;
      end
    end
  end

  always_comb begin
    w_state_d      = r_state;
    w_aw_sel_d     = r_aw_sel;
    w_rr_ptr_d     = r_rr_ptr;
    mst_aw_valid_o = 1'b0;
    slv_aw_ready_o = '0;
    w_aw_hs        = 1'b0;
    unique case (r_state)
      AwIdle: begin
        if (w_arb_found && (r_count < CntMax)) begin
          w_state_d  = AwLocked;
          w_aw_sel_d = w_arb_idx;
        end
      end
      AwLocked: begin
        mst_aw_valid_o           = slv_aw_valid_i[r_aw_sel];
        slv_aw_ready_o[r_aw_sel] = mst_aw_ready_i;
        w_aw_hs                  = mst_aw_valid_o & mst_aw_ready_i;
        if (w_aw_hs) begin
          w_state_d  = AwIdle;
          w_rr_ptr_d = (r_aw_sel == SelLast) ? '0 : r_aw_sel + 1'b1;
        end
      end
      default: w_state_d = AwIdle;
    endcase
  end

  always_comb begin
    w_w_active = !w_fifo_empty;
    w_w_sel    = w_head;
`ifdef AXI_MUX_W_BYPASS_EN
    if (w_fifo_empty && w_aw_hs) begin
      w_w_active = 1'b1;
      w_w_sel    = r_aw_sel;
    end
`endif
    mst_w_valid_o = 1'b0;
    slv_w_ready_o = '0;
    mst_w_sel_o   = '0;
    w_pop         = 1'b0;
    if (w_w_active) begin
      mst_w_sel_o            = w_w_sel;
      mst_w_valid_o          = slv_w_valid_i[w_w_sel];
      slv_w_ready_o[w_w_sel] = mst_w_ready_i;
      w_pop                  = mst_w_valid_o & mst_w_ready_i & slv_w_last_i[w_w_sel];
    end
  end

  // A pop while empty can only be a fall-through burst: it cancels the matching push.
  assign w_fifo_pop  = w_pop & ~w_fifo_empty;
  assign w_fifo_push = w_aw_hs & ~(w_pop & w_fifo_empty);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= AwIdle;
      r_aw_sel <= '0;
      r_rr_ptr <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_state  <= w_state_d;
      r_aw_sel <= w_aw_sel_d;
      r_rr_ptr <= w_rr_ptr_d;
      if (w_fifo_push) r_wr_ptr <= (r_wr_ptr == PtrLast) ? '0 : r_wr_ptr + 1'b1;
      if (w_fifo_pop)  r_rd_ptr <= (r_rd_ptr == PtrLast) ? '0 : r_rd_ptr + 1'b1;
      if (w_fifo_push && !w_fifo_pop)      r_count <= r_count + 1'b1;
      else if (w_fifo_pop && !w_fifo_push) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_fifo_push) r_fifo[r_wr_ptr] <= r_aw_sel;
  end

endmodule

// File: tb/tb_axi_mux_aw_w_arbiter.sv
// Randomized and directed bench for axi_mux_aw_w_arbiter against a queue-based model.
// Follows AXI_MUX_W_BYPASS_EN the same way the design does.
module tb_axi_mux_aw_w_arbiter;
  localparam int N    = 4;
  localparam int MaxW = 2;
  localparam int SW   = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  slv_aw_valid, slv_aw_ready;
  logic          mst_aw_valid, mst_aw_ready;
  logic [SW-1:0] mst_aw_sel;
  logic [N-1:0]  slv_w_valid, slv_w_last, slv_w_ready;
  logic          mst_w_valid, mst_w_ready;
  logic [SW-1:0] mst_w_sel;
  logic          w_fifo_full, w_fifo_empty;

  always #5 clk = ~clk;

  axi_mux_aw_w_arbiter #(
    .NoSlvPorts(N),
    .MaxWTrans (MaxW)
  ) u_dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .slv_aw_valid_i(slv_aw_valid),
    .slv_aw_ready_o(slv_aw_ready),
    .mst_aw_valid_o(mst_aw_valid),
    .mst_aw_ready_i(mst_aw_ready),
    .mst_aw_sel_o  (mst_aw_sel),
    .slv_w_valid_i (slv_w_valid),
    .slv_w_last_i  (slv_w_last),
    .slv_w_ready_o (slv_w_ready),
    .mst_w_valid_o (mst_w_valid),
    .mst_w_ready_i (mst_w_ready),
    .mst_w_sel_o   (mst_w_sel),
    .w_fifo_full_o (w_fifo_full),
    .w_fifo_empty_o(w_fifo_empty)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
  endtask

  // Model: a pending grant (-1 when none), the last granted index, the round-robin
  // pointer, and the list of AW-ordered W owners.
  int m_pend     = -1;
  int m_last_sel = 0;
  int m_rr       = 0;
  int m_q[$];

  typedef struct {
    logic         aw_valid;
    logic [N-1:0] aw_ready;
    int           aw_sel;
    logic         w_valid;
    logic [N-1:0] w_ready;
    int           w_sel;
    int           owner;
    logic         hs;
    logic         pop;
    logic         full;
    logic         empty;
  } exp_t;

  function automatic exp_t model_out();
    exp_t e;
    e.aw_valid = 1'b0;
    e.aw_ready = '0;
    e.aw_sel   = m_last_sel;
    e.w_valid  = 1'b0;
    e.w_ready  = '0;
    e.w_sel    = 0;
    e.owner    = -1;
    if (m_pend >= 0) begin
      e.aw_valid = slv_aw_valid[m_pend];
      if (mst_aw_ready) e.aw_ready[m_pend] = 1'b1;
    end
    e.hs = e.aw_valid && mst_aw_ready;
    if (m_q.size() > 0) e.owner = m_q[0];
`ifdef AXI_MUX_W_BYPASS_EN
    else if (e.hs) e.owner = m_pend;
`endif
    if (e.owner >= 0) begin
      e.w_sel   = e.owner;
      e.w_valid = slv_w_valid[e.owner];
      if (mst_w_ready) e.w_ready[e.owner] = 1'b1;
    end
    e.pop   = (e.owner >= 0) && e.w_valid && mst_w_ready && slv_w_last[e.owner];
    e.full  = (m_q.size() == MaxW);
    e.empty = (m_q.size() == 0);
    return e;
  endfunction

  always @(posedge clk) begin : model_p
    exp_t e;
    int   qsz;
    bit   bypassed;
    e   = model_out();
    qsz = m_q.size();
    if (rst) begin
      m_pend     = -1;
      m_last_sel = 0;
      m_rr       = 0;
      m_q.delete();
    end else begin
      bypassed = (qsz == 0) && (e.owner >= 0);
      if (e.pop && !bypassed) void'(m_q.pop_front());
      if (e.hs) begin
        if (!(bypassed && e.pop)) m_q.push_back(m_pend);
        m_rr   = (m_pend + 1) % N;
        m_pend = -1;
      end else if (m_pend < 0 && qsz < MaxW) begin
        for (int k = 0; k < N; k++) begin
          if (slv_aw_valid[(m_rr + k) % N]) begin
            m_pend     = (m_rr + k) % N;
            m_last_sel = m_pend;
            break;
          end
        end
      end
    end
  end

  always @(negedge clk) begin : compare_p
    exp_t e;
    if (chk_en) begin
      e = model_out();
      check("aw_chan", {25'd0, mst_aw_valid, slv_aw_ready, mst_aw_sel},
            {25'd0, e.aw_valid, e.aw_ready, SW'(e.aw_sel)});
      check("w_chan", {25'd0, mst_w_valid, slv_w_ready, mst_w_sel},
            {25'd0, e.w_valid, e.w_ready, SW'(e.w_sel)});
      check("fifo_flags", {30'd0, w_fifo_full, w_fifo_empty}, {30'd0, e.full, e.empty});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    slv_aw_valid = '0;
    mst_aw_ready = 1'b0;
    slv_w_valid  = '0;
    slv_w_last   = '0;
    mst_w_ready  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic do_aw(input int idx);
    bit done = 1'b0;
    slv_aw_valid = N'(1 << idx);
    mst_aw_ready = 1'b1;
    for (int c = 0; c < 10 && !done; c++) begin
      #2;
      if (mst_aw_valid && mst_aw_ready) done = 1'b1;
      tick();
    end
    slv_aw_valid = '0;
    mst_aw_ready = 1'b0;
    check("aw_handshake_seen", 32'(done), 32'd1);
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    slv_aw_valid = '1;
    mst_aw_ready = 1'b1;
    slv_w_valid  = '1;
    slv_w_last   = '1;
    mst_w_ready  = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    #2;
    check("rst_aw_valid", 32'(mst_aw_valid), 32'd0);
    check("rst_aw_ready", 32'(slv_aw_ready), 32'd0);
    check("rst_aw_sel", 32'(mst_aw_sel), 32'd0);
    check("rst_w_valid", 32'(mst_w_valid), 32'd0);
    check("rst_w_ready", 32'(slv_w_ready), 32'd0);
    check("rst_w_sel", 32'(mst_w_sel), 32'd0);
    check("rst_full", 32'(w_fifo_full), 32'd0);
    check("rst_empty", 32'(w_fifo_empty), 32'd1);
    tick();
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_rr();
    int rr_exp[4] = '{1, 3, 1, 3};
    int grants[$];
    bit prev_v = 1'b0;
    bit gap_ok = 1'b1;
    do_reset();
    slv_aw_valid = 4'b1010;
    mst_aw_ready = 1'b1;
    slv_w_valid  = '1;
    slv_w_last   = '1;
    mst_w_ready  = 1'b1;
    for (int c = 0; c < 40 && grants.size() < 4; c++) begin
      #2;
      if (mst_aw_valid && mst_aw_ready) begin
        grants.push_back(int'(mst_aw_sel));
        if (prev_v) gap_ok = 1'b0;
      end
      prev_v = mst_aw_valid;
      tick();
    end
    idle_inputs();
    check("rr_grant_count", 32'(grants.size()), 32'd4);
    for (int i = 0; i < grants.size() && i < 4; i++) check("rr_grant_order", grants[i], rr_exp[i]);
    check("rr_idle_gap", 32'(gap_ok), 32'd1);
  endtask

  task automatic test_sel_hold();
    do_reset();
    slv_aw_valid = 4'b0100;
    mst_aw_ready = 1'b0;
    tick();
    slv_aw_valid = 4'b0101;
    for (int c = 0; c < 5; c++) begin
      #2;
      check("hold_sel", 32'(mst_aw_sel), 32'd2);
      check("hold_aw_ready", 32'(slv_aw_ready), 32'd0);
      tick();
    end
    mst_aw_ready = 1'b1;
    #2;
    check("hold_release_ready", 32'(slv_aw_ready), 32'b0100);
    tick();
    idle_inputs();
  endtask

  task automatic test_w_order();
    do_reset();
    do_aw(2);
    do_aw(0);
    slv_w_valid = 4'b0001;
    mst_w_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #2;
      check("word_blocked_ready", 32'(slv_w_ready[0]), 32'd0);
      check("word_owner_first", 32'(mst_w_sel), 32'd2);
      tick();
    end
    slv_w_valid = 4'b0101;
    slv_w_last  = 4'b0100;
    #2;
    check("word_last_of_2", 32'(slv_w_ready), 32'b0100);
    tick();
    for (int b = 0; b < 3; b++) begin
      slv_w_valid = 4'b0001;
      slv_w_last  = (b == 2) ? 4'b0001 : 4'b0000;
      #2;
      check("word_burst0_ready", 32'(slv_w_ready), 32'b0001);
      tick();
    end
    idle_inputs();
    #2;
    check("word_drained", 32'(w_fifo_empty), 32'd1);
    tick();
  endtask

  task automatic test_full();
    do_reset();
    do_aw(0);
    do_aw(1);
    slv_aw_valid = 4'b0100;
    mst_aw_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #2;
      check("full_flag", 32'(w_fifo_full), 32'd1);
      check("full_no_grant", 32'(mst_aw_valid), 32'd0);
      tick();
    end
    slv_w_valid = 4'b0001;
    slv_w_last  = 4'b0001;
    mst_w_ready = 1'b1;
    #2;
    check("full_pop_ready", 32'(slv_w_ready), 32'b0001);
    tick();
    slv_w_valid = '0;
    slv_w_last  = '0;
    #2;
    check("full_after_pop", 32'(w_fifo_full), 32'd0);
    check("full_grant_wait", 32'(mst_aw_valid), 32'd0);
    tick();
    #2;
    check("full_grant_now", 32'(mst_aw_valid), 32'd1);
    check("full_grant_sel", 32'(mst_aw_sel), 32'd2);
    tick();
    idle_inputs();
  endtask

  task automatic test_bypass();
    do_reset();
    slv_aw_valid = 4'b1000;
    mst_aw_ready = 1'b1;
    slv_w_valid  = 4'b1000;
    slv_w_last   = 4'b1000;
    mst_w_ready  = 1'b1;
    tick();
    #2;
    check("byp_aw_hs", 32'(mst_aw_valid), 32'd1);
`ifdef AXI_MUX_W_BYPASS_EN
    check("byp_w_valid", 32'(mst_w_valid), 32'd1);
    check("byp_w_ready", 32'(slv_w_ready), 32'b1000);
    check("byp_w_sel", 32'(mst_w_sel), 32'd3);
    tick();
    idle_inputs();
    #2;
    check("byp_empty", 32'(w_fifo_empty), 32'd1);
`else
    check("nobyp_w_held", 32'(mst_w_valid), 32'd0);
    check("nobyp_w_ready", 32'(slv_w_ready), 32'd0);
    tick();
    slv_aw_valid = '0;
    #2;
    check("nobyp_w_next", 32'(slv_w_ready), 32'b1000);
    check("nobyp_not_empty", 32'(w_fifo_empty), 32'd0);
    tick();
    idle_inputs();
    #2;
    check("nobyp_empty", 32'(w_fifo_empty), 32'd1);
`endif
    tick();
  endtask

  task automatic test_mid_reset();
    do_reset();
    do_aw(1);
    slv_w_valid = 4'b0010;
    slv_w_last  = 4'b0000;
    mst_w_ready = 1'b1;
    #2;
    check("midrst_before", 32'(slv_w_ready), 32'b0010);
    rst = 1'b1;
    tick();
    #2;
    check("midrst_ready", 32'(slv_w_ready), 32'd0);
    check("midrst_empty", 32'(w_fifo_empty), 32'd1);
    rst = 1'b0;
    idle_inputs();
    tick();
  endtask

  task automatic random_phase();
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      slv_aw_valid = N'($urandom_range(0, 15));
      mst_aw_ready = ($urandom_range(0, 3) != 0);
      slv_w_valid  = N'($urandom_range(0, 15));
      slv_w_last   = N'($urandom_range(0, 15));
      mst_w_ready  = ($urandom_range(0, 3) != 0);
      rst          = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_rr();
    test_sel_hold();
    test_w_order();
    test_full();
    test_bypass();
    test_mid_reset();
    random_phase();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axi_mux_aw_w_arbiter.md
# axi_mux_aw_w_arbiter

Controller for the write side of the crossbar's per-subordinate mux. It shares one master AW/W port among `NoSlvPorts` demux outputs: round-robin arbitration on AW, with the granted index held stable until the handshake completes. Each granted index is recorded in a write-order FIFO, so W beats are routed in AW order. The block drives handshakes and select indices only; the payload muxes sit outside it and are steered by `mst_aw_sel_o` and `mst_w_sel_o`.

## Interface
- `NoSlvPorts`, default 4: number of requesting slave ports (≥2).
- `MaxWTrans`, default 8: write-order FIFO depth; maximum AWs accepted whose W burst is not yet finished (≥1).
- `SelectWidth`, default `$clog2(NoSlvPorts)`: dependent, do not override.
- `clk_i` input 1: clock. One clock domain.
- `rst_i` input 1: reset. Synchronous and active-high.
- `slv_aw_valid_i` input NoSlvPorts: AW valid per requester.
- `slv_aw_ready_o` output NoSlvPorts: AW ready per requester; one-hot or zero.
- `mst_aw_valid_o` output 1: AW valid to the subordinate.
- `mst_aw_ready_i` input 1: AW ready from the subordinate.
- `mst_aw_sel_o` output SelectWidth: index of the granted AW requester.
- `slv_w_valid_i` input NoSlvPorts: W valid per requester.
- `slv_w_last_i` input NoSlvPorts: W last per requester.
- `slv_w_ready_o` output NoSlvPorts: W ready per requester; one-hot or zero.
- `mst_w_valid_o` output 1: W valid to the subordinate.
- `mst_w_ready_i` input 1: W ready from the subordinate.
- `mst_w_sel_o` output SelectWidth: index of the requester currently owning W.
- `w_fifo_full_o` output 1: write-order FIFO full.
- `w_fifo_empty_o` output 1: write-order FIFO empty.

## Operation
**AW state machine: `AW_IDLE`, `AW_LOCKED`.**
- In `AW_IDLE`, when any `slv_aw_valid_i` bit is set and the FIFO count is below `MaxWTrans`:
  - Pick the first valid index at or after `rr_ptr`, searching upward and wrapping from `NoSlvPorts-1` to 0.
  - Register it into `aw_sel`.
  - Move to `AW_LOCKED`.
- In `AW_LOCKED`:
  - `mst_aw_valid_o = slv_aw_valid_i[aw_sel]`.
  - `slv_aw_ready_o[aw_sel] = mst_aw_ready_i`; all other bits are 0.
  - `mst_aw_sel_o = aw_sel`, held stable for the whole state.
- On the handshake (`mst_aw_valid_o & mst_aw_ready_i`):
  - Push `aw_sel` into the FIFO.
  - Set `rr_ptr = aw_sel+1`, wrapping at `NoSlvPorts`.
  - Return to `AW_IDLE`.
- If the requester drops valid while in `AW_LOCKED`, that is a protocol violation by the requester. The block stays locked; nothing is pushed.

**W routing.**
- The FIFO head is the W owner; `mst_w_sel_o` = head.
- When the FIFO is non-empty:
  - `mst_w_valid_o = slv_w_valid_i[head]`.
  - `slv_w_ready_o[head] = mst_w_ready_i`.
- When the FIFO is empty, all W outputs are 0.
- Pop when `mst_w_valid_o & mst_w_ready_i & slv_w_last_i[head]`. Non-last beats never pop.

**FIFO.**
- Count width is `$clog2(MaxWTrans+1)`; read and write pointers wrap modulo `MaxWTrans`.
- A simultaneous push and pop leaves the count unchanged.
- Push is never attempted when full: the AW grant is gated by the count at `AW_IDLE`, and the count can only fall while in `AW_LOCKED`.

**Reset.**
- `rst_i` clears the state machine to `AW_IDLE`, `rr_ptr` to 0, and FIFO pointers and count to 0. This holds mid-burst as well; in-flight ownership is discarded.
- Reset values of outputs: all valid and ready outputs 0, `mst_aw_sel_o = 0`, `mst_w_sel_o = 0`, `w_fifo_full_o = 0`, `w_fifo_empty_o = 1`.

## Timing
- AW latency: `mst_aw_valid_o` rises 1 cycle after the requester's valid is sampled in `AW_IDLE`.
- AW throughput: at most one AW per 2 cycles (`AW_IDLE` → `AW_LOCKED` → `AW_IDLE`).
- W: without the macro, the first W beat is forwarded at the earliest the cycle after the AW handshake. Once ownership is set, W runs at 1 beat/cycle.
- Pop takes effect at the clock edge of the last-beat handshake; the next owner's W may pass in the following cycle.
- All ready outputs are combinational from `mst_*_ready_i`. There is no combinational path from `slv_aw_valid_i` to `slv_aw_ready_o`.

## Configuration
- `AXI_MUX_W_BYPASS_EN`, defined:
  - When the FIFO is empty and an AW handshake occurs this cycle, W ownership is `aw_sel` in the same cycle (fall-through).
  - If that cycle's W beat is last and handshakes, push and pop cancel and the count stays 0.
- `AXI_MUX_W_BYPASS_EN`, undefined:
  - W is routed only from a registered FIFO head.
  - A W beat is never forwarded in the AW handshake cycle.

## Test plan
- **Reset values:** Assert `rst_i` for 2 cycles with all inputs at 1 → all valid/ready outputs 0, both sel outputs 0, `w_fifo_empty_o = 1`.
- **Round-robin order:** `NoSlvPorts = 4`; requesters 1 and 3 hold AW valid; `mst_aw_ready_i = 1` → grants in order 1, 3, 1, 3; each `mst_aw_valid_o` pulse is preceded by one idle cycle.
- **Sel stability under backpressure:** `mst_aw_ready_i = 0` for 5 cycles while requester 2 is locked and requester 0 raises valid → `mst_aw_sel_o` stays 2 for all 5 cycles; `slv_aw_ready_o = 0`.
- **W ordering:** AW from 2, then from 0; requester 0's W valid is raised first → `slv_w_ready_o[0]` stays 0 until requester 2's last beat completes, then requester 0's 3-beat burst passes in 3 cycles.
- **FIFO full:** `MaxWTrans = 2`; two AWs accepted with no W traffic → `w_fifo_full_o = 1` and a third AW is not granted. After one last-beat pop, the third is granted 1 cycle later.
- **Bypass / mid-burst reset:** With `AXI_MUX_W_BYPASS_EN` defined, a single-beat W arrives alongside the AW handshake → W is forwarded that same cycle and `w_fifo_empty_o` stays 1. Separately, asserting `rst_i` mid-burst → `slv_w_ready_o` is 0 the next cycle.
